// File: rtl/modulo6_sequence_checker.sv
// -----------------------------------------------------------------------------
// modulo6_sequence_checker
//
// Receive-side monitor for a synchronous modulo-6 counter's {q2,q1,q0} output.
// It locks onto the count stream, then checks that every valid sample is either
// a hold or a single mod-6 advance. It also counts 5->0 wraps seen while locked.
//
// Optional feature macro: MOD6_CHK_STALL_DET_EN
//   When defined, a run of more than STALL_MAX consecutive valid hold samples
//   while LOCKED is treated as a violation. When undefined, holds are unlimited
//   and no hold counter is built.
//
// Ports
//   clk         in   1       rising-edge clock, shared with the counter
//   reset       in   1       asynchronous, active-low (0 = reset)
//   cnt_vld     in   1       cnt is meaningful this cycle
//   cnt         in   3       {q2,q1,q0} from the counter, q2 = MSB
//   clr         in   1       synchronous clear of fault/sticky/wrap state
//   locked      out  1       1 while the FSM is in LOCKED
//   err         out  1       one-cycle pulse on a detected violation
//   err_sticky  out  1       set by err, cleared only by reset or clr
//   wrap_cnt    out  WRAP_W  5->0 transitions seen while LOCKED (saturating)
//   last_val    out  3       last valid sample registered
// -----------------------------------------------------------------------------
module modulo6_sequence_checker #(
  parameter int unsigned LOCK_STEPS = 2,   // 1..7
  parameter int unsigned WRAP_W     = 8,
  parameter int unsigned STALL_MAX  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_vld,
  input  logic [2:0]        cnt,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [2:0]        last_val
);

  // Elaboration-time parameter sanity checks.
  if (LOCK_STEPS < 1 || LOCK_STEPS > 7) begin : g_bad_lock_steps
    $error("LOCK_STEPS must be in 1..7");
  end
  if (STALL_MAX < 1) begin : g_bad_stall_max
    $error("STALL_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_e;

  localparam logic [2:0] LOCK_STEPS_L = 3'(LOCK_STEPS);

  state_e              state_q,      state_d;
  logic [2:0]          good_run_q,   good_run_d;
  logic                have_ref_q,   have_ref_d;
  logic [2:0]          last_val_q,   last_val_d;
  logic                err_q,        err_d;
  logic                err_sticky_q, err_sticky_d;
  logic [WRAP_W-1:0]   wrap_cnt_q,   wrap_cnt_d;

  // Step classification against the previous valid sample.
  logic [2:0] expect_next;
  logic       val_legal;
  logic       is_hold;
  logic       is_adv;
  logic       step_ok;
  logic       stall;

  assign expect_next = (last_val_q == 3'd5) ? 3'd0 : last_val_q + 3'd1;
  assign val_legal   = (cnt <= 3'd5);
  assign is_hold     = (cnt == last_val_q);
  assign is_adv      = (cnt == expect_next);
  assign step_ok     = val_legal && (is_hold || is_adv);

`ifdef MOD6_CHK_STALL_DET_EN
  // Wide enough to hold STALL_MAX; the run never grows past it because the
  // next hold is flagged as a stall and leaves LOCKED.
  localparam int unsigned HOLD_W = $clog2(STALL_MAX + 1) + 1;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign stall = cnt_vld && (state_q == LOCKED) && val_legal && is_hold &&
                 (hold_cnt_q >= HOLD_W'(STALL_MAX));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != LOCKED) begin
      hold_cnt_d = '0;
    end else if (cnt_vld) begin
      hold_cnt_d = (val_legal && is_hold) ? hold_cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign stall = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    good_run_d   = good_run_q;
    have_ref_d   = have_ref_q;
    last_val_d   = last_val_q;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    wrap_cnt_d   = wrap_cnt_q;

    if (clr) begin
      err_sticky_d = 1'b0;
      wrap_cnt_d   = '0;
    end

    if (cnt_vld) begin
      last_val_d = cnt;
      unique case (state_q)
        SEARCH: begin
          if (!val_legal) begin
            // Nothing trustworthy to compare the next sample against.
            good_run_d = '0;
            have_ref_d = 1'b0;
          end else if (!have_ref_q) begin
            have_ref_d = 1'b1;
            good_run_d = '0;
          end else if (is_adv) begin
            if (3'(good_run_q + 3'd1) == LOCK_STEPS_L) begin
              state_d    = LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_run_q + 3'd1;
            end
          end else if (!is_hold) begin
            // Bad step with a legal value: re-seed from this sample.
            good_run_d = '0;
            have_ref_d = 1'b1;
          end
        end
        LOCKED: begin
          // A violation overrides a simultaneous clr for err/err_sticky.
          if (!step_ok || stall) begin
            state_d      = FAULT;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
          end else if (is_adv && (last_val_q == 3'd5) && !clr &&
                       (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
          end
        end
        default: ;  // FAULT: only last_val tracks the stream
      endcase
    end

    if ((state_q == FAULT) && clr) begin
      state_d    = SEARCH;
      good_run_d = '0;
      have_ref_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEARCH;
      good_run_q   <= '0;
      have_ref_q   <= 1'b0;
      last_val_q   <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      have_ref_q   <= have_ref_d;
      last_val_q   <= last_val_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign last_val   = last_val_q;

endmodule

// File: tb/tb_modulo6_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_modulo6_sequence_checker
//
// Directed-vector bench for modulo6_sequence_checker (LOCK_STEPS=2, WRAP_W=8,
// STALL_MAX=3). Expected values are hand-computed per step.
// -----------------------------------------------------------------------------
module tb_modulo6_sequence_checker;

  logic       clk;
  logic       reset;
  logic       cnt_vld;
  logic [2:0] cnt;
  logic       clr;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [7:0] wrap_cnt;
  logic [2:0] last_val;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MOD6_CHK_STALL_DET_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  modulo6_sequence_checker #(
    .LOCK_STEPS (2),
    .WRAP_W     (8),
    .STALL_MAX  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_vld    (cnt_vld),
    .cnt        (cnt),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt),
    .last_val   (last_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; returns #1 after the rising edge.
  task automatic step(input logic v, input logic [2:0] c, input logic cl);
    cnt_vld = v;
    cnt     = c;
    clr     = cl;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".locked"},     32'(locked),     32'd0);
    check({tag, ".err"},        32'(err),        32'd0);
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'd0);
    check({tag, ".last_val"},   32'(last_val),   32'd0);
  endtask

  initial begin
    logic [2:0] v;
    reset   = 1'b0;
    cnt_vld = 1'b0;
    cnt     = 3'd0;
    clr     = 1'b0;

    // ---- 1: reset state, then lock on 0,1,2 ---------------------------------
    #2;
    check_all_zero("reset");
    #10 reset = 1'b1;                       // t=12, away from the edge
    step(1'b1, 3'd0, 1'b0);
    check("t1.s0.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd1, 1'b0);
    check("t1.s1.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd2, 1'b0);
    check("t1.s2.locked",   32'(locked),   32'd1);
    check("t1.s2.err",      32'(err),      32'd0);
    check("t1.s2.last_val", 32'(last_val), 32'd2);

    // ---- 2: two wraps: 3,4,5,0,1,2,3,4,5,0 ----------------------------------
    v = 3'd2;
    for (int i = 0; i < 10; i++) begin
      v = (v == 3'd5) ? 3'd0 : v + 3'd1;
      step(1'b1, v, 1'b0);
      check("t2.err", 32'(err), 32'd0);
    end
    check("t2.wrap_cnt", 32'(wrap_cnt), 32'd2);
    check("t2.locked",   32'(locked),   32'd1);

    // ---- 3: locked at 3, inject 5 -> fault; clr -> SEARCH -------------------
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    check("t3.pre.locked", 32'(locked), 32'd1);
    step(1'b1, 3'd5, 1'b0);
    check("t3.err",        32'(err),        32'd1);
    check("t3.err_sticky", 32'(err_sticky), 32'd1);
    check("t3.locked",     32'(locked),     32'd0);
    check("t3.last_val",   32'(last_val),   32'd5);
    step(1'b0, 3'd0, 1'b0);
    check("t3.pulse_end.err",  32'(err),        32'd0);
    check("t3.pulse_end.stky", 32'(err_sticky), 32'd1);
    check("t3.pulse_end.wrap", 32'(wrap_cnt),   32'd2);
    step(1'b0, 3'd0, 1'b1);
    check("t3.clr.err_sticky", 32'(err_sticky), 32'd0);
    check("t3.clr.wrap_cnt",   32'(wrap_cnt),   32'd0);
    check("t3.clr.locked",     32'(locked),     32'd0);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    check("t3.relock1.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd2, 1'b0);
    check("t3.relock2.locked", 32'(locked), 32'd1);

    // ---- 4: gaps around an illegal value 6 ----------------------------------
    step(1'b0, 3'd6, 1'b0);
    step(1'b0, 3'd7, 1'b0);
    check("t4.gap.err",      32'(err),      32'd0);
    check("t4.gap.locked",   32'(locked),   32'd1);
    check("t4.gap.last_val", 32'(last_val), 32'd2);
    step(1'b1, 3'd6, 1'b0);
    check("t4.bad.err",      32'(err),      32'd1);
    check("t4.bad.locked",   32'(locked),   32'd0);
    check("t4.bad.last_val", 32'(last_val), 32'd6);
    step(1'b0, 3'd6, 1'b0);
    check("t4.after.err", 32'(err), 32'd0);
    step(1'b0, 3'd0, 1'b1);

    // SEARCH: 0 (ref), 2 (bad step, re-seed), 3 (+1), 3 (hold), 4 (+1 -> lock)
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    check("t4.srch.bad.err", 32'(err), 32'd0);
    step(1'b1, 3'd3, 1'b0);
    check("t4.srch.adv1.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd3, 1'b0);
    check("t4.srch.hold.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd4, 1'b0);
    check("t4.srch.adv2.locked", 32'(locked),     32'd1);
    check("t4.srch.sticky",      32'(err_sticky), 32'd0);

    // ---- 5: hold at 4 for four valid samples --------------------------------
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd4, 1'b0);
      check("t5.hold.err", 32'(err), 32'((STALL_ON && i == 3) ? 1 : 0));
    end
    check("t5.locked", 32'(locked), 32'(STALL_ON ? 0 : 1));

    // ---- 6: async reset while LOCKED with wrap_cnt=3 ------------------------
    #3 reset = 1'b0;
    #1 reset = 1'b1;                        // released at edge+5 (falling edge)
    #1;
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    v = 3'd2;
    for (int i = 0; i < 16; i++) begin      // 3,4,5,0 then 1..5,0 twice
      v = (v == 3'd5) ? 3'd0 : v + 3'd1;
      step(1'b1, v, 1'b0);
    end
    check("t6.pre.wrap_cnt", 32'(wrap_cnt), 32'd3);
    check("t6.pre.locked",   32'(locked),   32'd1);
    cnt_vld = 1'b1;
    cnt     = 3'd1;
    #2 reset = 1'b0;                        // mid-cycle, no clock edge
    #1;
    check_all_zero("t6.async");
    #1 reset = 1'b1;
    cnt_vld = 1'b0;
    step(1'b1, 3'd3, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    check("t6.relock1.locked", 32'(locked), 32'd0);
    step(1'b1, 3'd5, 1'b0);
    check("t6.relock2.locked", 32'(locked), 32'd1);

    // ---- clr coinciding with a LOCKED violation -----------------------------
    step(1'b1, 3'd0, 1'b0);
    check("clrv.pre.wrap_cnt", 32'(wrap_cnt), 32'd1);
    step(1'b1, 3'd3, 1'b1);
    check("clrv.err",        32'(err),        32'd1);
    check("clrv.err_sticky", 32'(err_sticky), 32'd1);
    check("clrv.locked",     32'(locked),     32'd0);
    check("clrv.wrap_cnt",   32'(wrap_cnt),   32'd0);

    // ---- wrap counter saturation --------------------------------------------
    step(1'b0, 3'd0, 1'b1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    for (int w = 0; w < 260; w++) begin
      for (int k = 3; k < 9; k++) begin     // 3,4,5,0,1,2
        step(1'b1, 3'(k % 6), 1'b0);
      end
    end
    check("sat.wrap_cnt",   32'(wrap_cnt),   32'd255);
    check("sat.locked",     32'(locked),     32'd1);
    check("sat.err_sticky", 32'(err_sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
